// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: receiver states, oversampling constants, divisor helper
package uart_pkg;

    // Ticks per bit and the tick index that lands in the middle of a bit.
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    // Oversample-tick divisor, rounded to nearest: round(clk_freq / (baud * OVERSAMPLE)).
    function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud);
        int unsigned den;
        den = baud * OVERSAMPLE;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - divisor counter producing a one-cycle tick every DIV clocks
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   restart_i  synchronous restart: counter forced to 0, no tick this cycle
//   tick_o     one-cycle pulse when the counter wraps from DIV-1 to 0
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = !restart_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 16x oversampling UART receiver with a valid/ack byte holding register
//
// Optional feature macro: UART_RX_PARITY_EN (8E1 frame with even parity check; 8N1 otherwise).
//
// Ports:
//   iCLK         system clock
//   iRST_N       asynchronous active-low reset
//   iRXD         raw serial line, idle high, asynchronous to iCLK
//   iACK         consumer acknowledge, clears oVALID and oOVERRUN
//   oDATA        received byte, stable while oVALID=1
//   oVALID       byte available in holding register
//   oFRAME_ERR   one-cycle pulse: stop bit sampled low
//   oPARITY_ERR  one-cycle pulse: parity mismatch (always 0 in 8N1 builds)
//   oOVERRUN     sticky: a byte completed while oVALID=1 and was dropped
//   oBUSY        receiver is inside a frame (state other than IDLE)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iRXD,
    input  logic       iACK,
    output logic [7:0] oDATA,
    output logic       oVALID,
    output logic       oFRAME_ERR,
    output logic       oPARITY_ERR,
    output logic       oOVERRUN,
    output logic       oBUSY
);

    localparam int unsigned DIV = calc_divisor(CLK_FREQ, BAUD);

    logic           rx_meta_q, rxs_q;
    uart_rx_state_t state_q, state_d;
    logic [3:0]     samp_q, samp_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic           ferr_q;
    logic           tick, restart, mid_tick, end_tick;
    logic           deliver, frame_bad;

    // Restarting the divisor on the start edge puts every later sample point
    // a fixed number of ticks after the falling edge, i.e. at mid-bit.
    assign restart  = (state_q == ST_IDLE) && !rxs_q;
    assign mid_tick = tick && (samp_q == 4'(MID_SAMPLE - 1));
    assign end_tick = tick && (samp_q == 4'(OVERSAMPLE - 1));

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk_i     (iCLK),
        .rst_ni    (iRST_N),
        .restart_i (restart),
        .tick_o    (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic perr_q;
    logic stop_tick;
    assign stop_tick = (state_q == ST_STOP) && end_tick;
`endif

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (tick) begin
            samp_d = samp_q + 4'd1;
        end
        case (state_q)
            ST_IDLE: begin
                samp_d = 4'd0;
                if (!rxs_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_tick) begin
                    samp_d  = 4'd0;
                    bit_d   = 3'd0;
                    // Line back high at mid-bit: a glitch, not a start bit.
                    state_d = rxs_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (end_tick) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (end_tick) begin
                    par_bad_d = rxs_q ^ (^shift_q);
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (end_tick) begin
                    if (rxs_q) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off until the line idles so a break reports one error.
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && iACK) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (deliver) begin
            // An ack in the delivery cycle frees the register for the new byte.
            if (!valid_q || iACK) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= ST_IDLE;
            samp_q    <= 4'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= iRXD;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= frame_bad;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= stop_tick && par_bad_q;
        end
    end
    assign oPARITY_ERR = perr_q;
`else
    assign oPARITY_ERR = 1'b0;
`endif

    assign oDATA      = data_q;
    assign oVALID     = valid_q;
    assign oFRAME_ERR = ferr_q;
    assign oOVERRUN   = overrun_q;
    assign oBUSY      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial 8N1 receiver for the board-level UART_RXD pin; the receive-side counterpart of the board's serial transmit path. It oversamples the line at 16x baud, reconstructs bytes LSB-first, and presents each byte in a holding register with a valid/acknowledge handshake. Downstream consumers, such as the LCD character slots or a command decoder, read bytes from it.

## Interface
- CLK_FREQ, 50000000: iCLK frequency in Hz.
- BAUD, 115200: line bit rate. Divisor = round(CLK_FREQ / (BAUD*16)); 27 at defaults.
- iCLK  in  1  system clock (CLOCK_50 at top level).
- iRST_N  in  1  reset. One clock; reset is asynchronous and active-low.
- iRXD  in  1  raw serial line, idle high, asynchronous to iCLK.
- iACK  in  1  consumer acknowledge; clears oVALID.
- oDATA  out  8  received byte, held stable while oVALID=1.
- oVALID  out  1  byte available in holding register.
- oFRAME_ERR  out  1  one-cycle pulse: stop bit sampled 0.
- oPARITY_ERR  out  1  one-cycle pulse: parity mismatch. Constant 0 without the macro.
- oOVERRUN  out  1  sticky: a byte completed while oVALID=1 and was dropped.
- oBUSY  out  1  1 in any state other than IDLE.

## Operation
- iRXD passes through a 2-FF synchronizer with reset value 1. All logic uses the synchronized value rxs.
- Tick generator: counter 0..DIV-1 produces a 1-cycle tick at wrap. It is forced to 0 on entry to START.
- Sample counter: 4-bit, counts ticks within a bit.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE: rxs=0 → START.
  - START: on the 8th tick (mid-bit), rxs=0 → DATA with bit index 0; rxs=1 → IDLE (glitch rejected).
  - DATA: every 16th tick, shift rxs into the shift register MSB and shift right (LSB first). After the 8th bit → PARITY if the macro is defined, otherwise → STOP.
  - PARITY: sample on the 16th tick → STOP.
  - STOP: sample on the 16th tick.
    - rxs=1 → deliver the byte, then IDLE.
    - rxs=0 → pulse oFRAME_ERR, do not deliver, → WAIT_HIGH.
  - WAIT_HIGH: stays until rxs=1, then → IDLE. A break condition therefore produces one error, not repeated frames.
- Delivery into the holding register:
  - oVALID=0: load oDATA, set oVALID.
  - oVALID=1 and iACK=1 in the same cycle: load the new byte, oVALID stays 1, no overrun.
  - oVALID=1 and iACK=0: keep the old oDATA, drop the new byte, set oOVERRUN.
- iACK while oVALID=1 clears oVALID and oOVERRUN. iACK while oVALID=0 is ignored.

## Timing
- Reset values:
  - oDATA=8'h00; oVALID, oFRAME_ERR, oPARITY_ERR, oOVERRUN, oBUSY = 0.
  - FSM in IDLE; synchronizer = 1; counters = 0.
- Reset asserted mid-frame aborts the frame immediately with no delivery and no error pulse.
- Start-edge detection lags the pin by 2 cycles because of the synchronizer.
- oVALID rises 1 cycle after the stop-bit sample tick. The error pulses align to the same cycle.
- With parity configured, the parity result is registered and oPARITY_ERR pulses at stop time. The byte is still delivered on a parity error, provided the stop bit is good.
- oVALID falls the cycle after iACK is sampled high.
- Tolerates ±3% baud mismatch (mid-bit sampling over 10–11 bits).

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1.
  - A PARITY state sits between DATA and STOP.
  - Received parity bit must equal the XOR of the data bits (even parity); a mismatch pulses oPARITY_ERR.
- UART_RX_PARITY_EN undefined: frame is 8N1, there is no PARITY state, and oPARITY_ERR is tied to 0.

## Structure
- Package uart_pkg holds:
  - state enum uart_rx_state_t;
  - OVERSAMPLE=16 and MID_SAMPLE=8;
  - a function computing the divisor from CLK_FREQ/BAUD. The future transmitter reuses it.
- Sub-module uart_baud_tick: parameterized divisor counter with synchronous restart input and tick output. It is shared with the transmitter.

## Test plan
All scenarios use default parameters, bits driven at 434 cycles each.
- Send 0x55 8N1 → oDATA=0x55 with oVALID=1 about 10 bit times after the start edge; no error pulses; oBUSY=0 afterwards.
- Low glitch of 100 cycles on idle line → FSM returns to IDLE; oVALID stays 0.
- Send 0x3C with stop bit 0, then hold the line low for 2 bit times, then high → exactly one oFRAME_ERR pulse; no oVALID; next frame 0xA1 received correctly.
- Send 0x11 then 0x22 with no iACK → oDATA=0x11, oOVERRUN=1; iACK clears both oVALID and oOVERRUN.
- Send 0x11, then assert iACK in the exact delivery cycle of the second frame 0x22 → oDATA=0x22, oVALID=1, oOVERRUN=0.
- UART_RX_PARITY_EN defined: send 0xA5 with parity bit 1 → oPARITY_ERR pulse and oDATA=0xA5; parity bit 0 → no pulse. Assert iRST_N low mid-frame → all outputs at reset values.
